mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   MEM stage of the 5-stage RISC-V pipeline. It is the consumer of the EX/MEM
//   register: it executes loads and stores on an internal word-addressed data
//   memory, resolves beq, and loads the MEM/WB register. It returns writeback
//   data and forwarding data to EX and ID. The memory has a configurable access
//   latency; a wait counter holds the pipeline with stall_out until an access completes.
// PARAMETERS
//   ADDR_WIDTH   8   data memory word-index width; depth = 2**ADDR_WIDTH words of 32 bits
//   MEM_LATENCY  0   extra cycles per load/store; legal range 0..15 (4-bit wait counter)
// PORTS
//   clock                input   1   single clock; all state updates on posedge
//   reset                input   1   synchronous, active-high
//   mem_to_reg_in        input   1   EX/MEM WB control: writeback selects load data
//   reg_write_in         input   1   EX/MEM WB control: instruction writes rd
//   mem_read_in          input   1   EX/MEM MEM control: load
//   mem_write_in         input   1   EX/MEM MEM control: store
//   beq_instruction_in   input   1   EX/MEM: instruction is beq
//   flag_beq_in          input   1   EX/MEM: ALU equality flag
//   alu_result_in        input   32  EX/MEM: ALU result, also the byte address
//   mux2_result_in       input   32  EX/MEM: store data (forwarded rs2)
//   reg_rd_in            input   5   EX/MEM: destination register
//   stall_out            output  1   hold the IF/ID, ID/EX and EX/MEM registers (combinational)
//   branch_taken_out     output  1   beq_instruction_in & flag_beq_in (combinational)
//   mem_to_reg_out       output  1   MEM/WB register
//   reg_write_out        output  1   MEM/WB register
//   reg_rd_out           output  5   MEM/WB register; drives mem_wb_reg_rd of forwarding
//   alu_result_out       output  32  MEM/WB register
//   read_data_out        output  32  MEM/WB register: load data
//   wb_data_out          output  32  mem_to_reg_out ? read_data_out : alu_result_out; to EX as alu_data_mem_wb
//   fault_out            output  1   sticky out-of-range access flag (DMEM_BOUNDS_CHECK_EN only, else tied 0)
// BEHAVIOUR
//   - access = mem_read_in | mem_write_in. Word index = alu_result_in[ADDR_WIDTH+1:2]; bits [1:0] are ignored.
//   - FSM states: IDLE (wait_cnt==0) and WAIT (wait_cnt>0). stall_out = access & (wait_cnt != MEM_LATENCY).
//   - Edge with stall_out=1: wait_cnt++ (IDLE->WAIT). The MEM/WB register loads a bubble:
//     reg_write_out=0, mem_to_reg_out=0, reg_rd_out=0; alu_result_out and read_data_out hold their values.
//   - Edge with stall_out=0: wait_cnt<=0 (->IDLE) and MEM/WB loads the EX/MEM fields. Store: mem[idx]<=mux2_result_in,
//     committed exactly once, on this edge only. Load: read_data_out<=mem[idx] (asynchronous array read).
//   - MEM_LATENCY=0: stall_out never asserts. Each access has 1-cycle latency to MEM/WB.
//     MEM_LATENCY=N: stall_out is high for N cycles and the result is in MEM/WB on edge N+1.
//   - Upstream holds the EX/MEM inputs stable while stall_out=1; the block does not latch them.
//   - mem_read_in and mem_write_in both high: treated as a store; read_data_out <= pre-write word.
//   - Non-access instruction: never stalls. read_data_out <= 0.
//   - branch_taken_out is independent of stall and of the FSM.
//   - Reset: MEM/WB outputs all 0, wait_cnt=0, FSM IDLE, fault_out=0. Memory contents are not reset.
//     Reset during WAIT aborts the access; a pending store is discarded. Reset wins over every other event.
// CONFIGURATION
//   DMEM_BOUNDS_CHECK_EN defined: out-of-range = alu_result_in[31:ADDR_WIDTH+2] != 0.
//     On the completion edge of an out-of-range access: store suppressed, read_data_out<=0, fault_out<=1.
//     fault_out stays 1 until reset. The stall timing is unchanged.
//   Undefined: the upper address bits are ignored, so the address wraps modulo depth. fault_out is constant 0.
// TESTING
//   1 LAT=0: sw 0xDEADBEEF @0x10, then lw rd=7 @0x10 mem_to_reg=1 -> stall_out=0 throughout;
//     edge after lw: read_data_out=wb_data_out=0xDEADBEEF, reg_rd_out=7, reg_write_out=1.
//   2 LAT=3: lw @0x10 held stable -> stall_out=1 for 3 cycles with reg_write_out=0; 4th edge: data and rd=7 in MEM/WB.
//   3 beq: beq_instruction_in=1, flag=1 -> branch_taken_out=1 same cycle; flag=0 -> 0; stall_out=0.
//   4 LAT=3: sw 0x1234 @0x20, reset pulse in the 2nd wait cycle -> stall_out=0, outputs 0; later lw @0x20 != 0x1234 (prefilled 0).
//   5 add: rd=5, alu_result=42, reg_write=1 -> next edge reg_write_out=1, reg_rd_out=5, wb_data_out=42; no stall.
//   6 ADDR_WIDTH=8, sw 0xA5 @0x400: with the macro -> fault_out=1 sticky, word 0 unchanged; without -> word 0 = 0xA5.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: word-addressed data memory with configurable access latency, beq resolution and the MEM/WB register.
// Optional macro DMEM_BOUNDS_CHECK_EN enables out-of-range detection with a sticky fault_out.
module mem_stage #(
  parameter int ADDR_WIDTH  = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        beq_instruction_in,
  input  logic        flag_beq_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] mux2_result_in,
  input  logic [4:0]  reg_rd_in,
  output logic        stall_out,
  output logic        branch_taken_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [4:0]  reg_rd_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] read_data_out,
  output logic [31:0] wb_data_out,
  output logic        fault_out
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [31:0]             mem [DEPTH];
  logic                    access;
  logic                    oob;
  logic                    complete;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [31:0]             rd_word;

  logic                    mem_to_reg_p1;
  logic                    reg_write_p1;
  logic [4:0]              reg_rd_p1;
  logic [31:0]             alu_result_p1;
  logic [31:0]             read_data_p1;

  assign access  = mem_read_in | mem_write_in;
  assign idx     = alu_result_in[ADDR_WIDTH+1:2];
  assign rd_word = mem[idx];

  // IDLE implies wait_cnt == 0, so a zero-latency build never stalls.
  assign stall_out = access && ((state == IDLE) ? (LAT != 4'd0) : (wait_cnt != LAT));
  assign complete  = !reset && !stall_out;

  assign branch_taken_out = beq_instruction_in & flag_beq_in;

`ifdef DMEM_BOUNDS_CHECK_EN
  logic fault_q;

  assign oob       = |alu_result_in[31:ADDR_WIDTH+2];
  assign fault_out = fault_q;

  always_ff @(posedge clock) begin
    if (reset)
      fault_q <= 1'b0;
    else if (complete && access && oob)
      fault_q <= 1'b1;
  end
`else
  logic unused_addr_hi;

  assign oob            = 1'b0;
  assign fault_out      = 1'b0;
  assign unused_addr_hi = ^alu_result_in[31:ADDR_WIDTH+2];
`endif

  // Stores commit only on the completion edge, so a reset mid-wait drops them.
  always_ff @(posedge clock) begin
    if (complete && mem_write_in && !oob)
      mem[idx] <= mux2_result_in;
  end

  // EX/MEM -> MEM/WB boundary
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
      reg_rd_p1     <= 5'd0;
      alu_result_p1 <= 32'd0;
      read_data_p1  <= 32'd0;
    end else if (stall_out) begin
      state         <= WAIT;
      wait_cnt      <= wait_cnt + 4'd1;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
      reg_rd_p1     <= 5'd0;
    end else begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      mem_to_reg_p1 <= mem_to_reg_in;
      reg_write_p1  <= reg_write_in;
      reg_rd_p1     <= reg_rd_in;
      alu_result_p1 <= alu_result_in;
      read_data_p1  <= (access && !oob) ? rd_word : 32'd0;
    end
  end

  assign mem_to_reg_out = mem_to_reg_p1;
  assign reg_write_out  = reg_write_p1;
  assign reg_rd_out     = reg_rd_p1;
  assign alu_result_out = alu_result_p1;
  assign read_data_out  = read_data_p1;
  assign wb_data_out    = mem_to_reg_p1 ? read_data_p1 : alu_result_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one zero-latency and one 3-cycle-latency instance.
module tb_mem_stage;

  typedef struct packed {
    logic        m2r, rw, rdn, wrn, beq, flag;
    logic [31:0] alu, data;
    logic [4:0]  rd;
  } in_t;

  typedef struct packed {
    logic        wr, m2r;
    logic [4:0]  rd;
    logic [31:0] alu, rdata;
    logic        cmp_rdata;
  } rec_t;

  localparam in_t NOP = '0;

  logic clock, reset;
  in_t  in0, in3;
  logic trk0, trk3;
  int   n_chk, n_fail;
  rec_t q0[$], q3[$];

  logic        stall0, br0, m2r0, rw0, fault0;
  logic [4:0]  rd0;
  logic [31:0] alu0, rdat0, wb0;
  logic        stall3, br3, m2r3, rw3, fault3;
  logic [4:0]  rd3;
  logic [31:0] alu3, rdat3, wb3;

  mem_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(0)) dut0 (
    .clock(clock), .reset(reset),
    .mem_to_reg_in(in0.m2r), .reg_write_in(in0.rw), .mem_read_in(in0.rdn),
    .mem_write_in(in0.wrn), .beq_instruction_in(in0.beq), .flag_beq_in(in0.flag),
    .alu_result_in(in0.alu), .mux2_result_in(in0.data), .reg_rd_in(in0.rd),
    .stall_out(stall0), .branch_taken_out(br0), .mem_to_reg_out(m2r0),
    .reg_write_out(rw0), .reg_rd_out(rd0), .alu_result_out(alu0),
    .read_data_out(rdat0), .wb_data_out(wb0), .fault_out(fault0));

  mem_stage #(.ADDR_WIDTH(8), .MEM_LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .mem_to_reg_in(in3.m2r), .reg_write_in(in3.rw), .mem_read_in(in3.rdn),
    .mem_write_in(in3.wrn), .beq_instruction_in(in3.beq), .flag_beq_in(in3.flag),
    .alu_result_in(in3.alu), .mux2_result_in(in3.data), .reg_rd_in(in3.rd),
    .stall_out(stall3), .branch_taken_out(br3), .mem_to_reg_out(m2r3),
    .reg_write_out(rw3), .reg_rd_out(rd3), .alu_result_out(alu3),
    .read_data_out(rdat3), .wb_data_out(wb3), .fault_out(fault3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(input logic m2r, input logic rw, input logic rdn, input logic wrn,
                             input logic [31:0] alu, input logic [31:0] data, input logic [4:0] rd);
    in_t v;
    v = '0;
    v.m2r = m2r; v.rw = rw; v.rdn = rdn; v.wrn = wrn;
    v.alu = alu; v.data = data; v.rd = rd;
    return v;
  endfunction

  function automatic rec_t mkr(input logic wr, input logic m2r, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] rdata, input logic cmp);
    rec_t r;
    r.wr = wr; r.m2r = m2r; r.rd = rd; r.alu = alu; r.rdata = rdata; r.cmp_rdata = cmp;
    return r;
  endfunction

  task automatic cmp_rec(input string tag, input rec_t e, input logic wr, input logic m2r,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] wb);
    chk({tag, "_reg_write"}, 32'(wr), 32'(e.wr));
    chk({tag, "_mem_to_reg"}, 32'(m2r), 32'(e.m2r));
    chk({tag, "_reg_rd"}, 32'(rd), 32'(e.rd));
    chk({tag, "_alu_result"}, alu, e.alu);
    if (e.cmp_rdata) chk({tag, "_read_data"}, rdat, e.rdata);
    if (e.cmp_rdata || !e.m2r) chk({tag, "_wb_data"}, wb, e.m2r ? e.rdata : e.alu);
  endtask

  // Monitors: capture pre-edge stall/track/reset, compare just after the edge.
  always @(posedge clock) begin
    logic s, t, r;
    rec_t e;
    s = stall0; t = trk0; r = reset;
    #1;
    if (!r && s) begin
      chk("lat0_bubble_reg_write", 32'(rw0), 32'd0);
    end else if (!r && t) begin
      if (q0.size() == 0) chk("lat0_queue_underflow", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        cmp_rec("lat0", e, rw0, m2r0, rd0, alu0, rdat0, wb0);
      end
    end
  end

  always @(posedge clock) begin
    logic s, t, r;
    rec_t e;
    s = stall3; t = trk3; r = reset;
    #1;
    if (!r && s) begin
      chk("lat3_bubble_reg_write", 32'(rw3), 32'd0);
      chk("lat3_bubble_reg_rd", 32'(rd3), 32'd0);
      chk("lat3_bubble_mem_to_reg", 32'(m2r3), 32'd0);
    end else if (!r && t) begin
      if (q3.size() == 0) chk("lat3_queue_underflow", 32'd1, 32'd0);
      else begin
        e = q3.pop_front();
        cmp_rec("lat3", e, rw3, m2r3, rd3, alu3, rdat3, wb3);
      end
    end
  end

  task automatic issue0(input in_t v, input rec_t e);
    @(negedge clock);
    in0 = v; trk0 = 1'b1;
    q0.push_back(e);
    #1 chk("lat0_no_stall", 32'(stall0), 32'd0);
    @(posedge clock);
    #2 in0 = NOP; trk0 = 1'b0;
  endtask

  task automatic issue3(input in_t v, input rec_t e);
    int n;
    bit done;
    @(negedge clock);
    in3 = v; trk3 = 1'b1;
    q3.push_back(e);
    n = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clock);
      if (stall3) n++;
      else done = 1'b1;
    end
    chk("lat3_stall_cycles", 32'(n), 32'd3);
    #2 in3 = NOP; trk3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    in0 = NOP; in3 = NOP; trk0 = 1'b0; trk3 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("reset_lat0_reg_write", 32'(rw0), 32'd0);
    chk("reset_lat0_wb_data", wb0, 32'd0);
    chk("reset_lat0_read_data", rdat0, 32'd0);
    chk("reset_lat0_fault", 32'(fault0), 32'd0);
    chk("reset_lat3_reg_rd", 32'(rd3), 32'd0);
    chk("reset_lat3_alu_result", alu3, 32'd0);
    chk("reset_lat3_stall", 32'(stall3), 32'd0);

    // sw then lw, zero latency
    issue0(mk(0, 0, 0, 1, 32'h10, 32'hDEADBEEF, 0), mkr(0, 0, 0, 32'h10, 32'h0, 0));
    issue0(mk(1, 1, 1, 0, 32'h10, 32'h0, 7), mkr(1, 1, 7, 32'h10, 32'hDEADBEEF, 1));

    // ALU instruction passes through with read data cleared
    issue0(mk(0, 1, 0, 0, 32'd42, 32'h0, 5), mkr(1, 0, 5, 32'd42, 32'h0, 1));

    // beq resolution is combinational
    @(negedge clock);
    in0 = NOP; in0.beq = 1'b1; in0.flag = 1'b1;
    #1 chk("beq_taken", 32'(br0), 32'd1);
    chk("beq_no_stall", 32'(stall0), 32'd0);
    in0.flag = 1'b0;
    #1 chk("beq_not_taken", 32'(br0), 32'd0);
    in0 = NOP;

    // out-of-range store to 0x400 aliases word 0 unless bounds checking is built in
    issue0(mk(0, 0, 0, 1, 32'h0, 32'h0, 0), mkr(0, 0, 0, 32'h0, 32'h0, 0));
    issue0(mk(0, 0, 0, 1, 32'h400, 32'hA5, 0), mkr(0, 0, 0, 32'h400, 32'h0, 1));
`ifdef DMEM_BOUNDS_CHECK_EN
    chk("oob_fault_set", 32'(fault0), 32'd1);
    issue0(mk(1, 1, 1, 0, 32'h0, 32'h0, 3), mkr(1, 1, 3, 32'h0, 32'h0, 1));
    chk("oob_fault_sticky", 32'(fault0), 32'd1);
`else
    chk("oob_fault_tied_low", 32'(fault0), 32'd0);
    issue0(mk(1, 1, 1, 0, 32'h0, 32'h0, 3), mkr(1, 1, 3, 32'h0, 32'hA5, 1));
    chk("oob_fault_still_low", 32'(fault0), 32'd0);
`endif

    // three-cycle latency: sw then lw of the same word
    issue3(mk(0, 0, 0, 1, 32'h10, 32'hCAFEF00D, 0), mkr(0, 0, 0, 32'h10, 32'h0, 0));
    issue3(mk(1, 1, 1, 0, 32'h10, 32'h0, 7), mkr(1, 1, 7, 32'h10, 32'hCAFEF00D, 1));

    // reset in the second wait cycle discards a pending store
    issue3(mk(0, 0, 0, 1, 32'h20, 32'h0, 0), mkr(0, 0, 0, 32'h20, 32'h0, 0));
    @(negedge clock);
    in3 = mk(0, 0, 0, 1, 32'h20, 32'h1234, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0; in3 = NOP;
    #1 chk("abort_stall", 32'(stall3), 32'd0);
    chk("abort_reg_write", 32'(rw3), 32'd0);
    chk("abort_alu_result", alu3, 32'd0);
    chk("abort_wb_data", wb3, 32'd0);
    issue3(mk(1, 1, 1, 0, 32'h20, 32'h0, 9), mkr(1, 1, 9, 32'h20, 32'h0, 1));

    @(negedge clock);
    chk("lat0_queue_drained", 32'(q0.size()), 32'd0);
    chk("lat3_queue_drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
